// File: rtl/muldiv_iter_if.sv
// Execute-stage handshake and operand/result bundle for the iterative multiply/divide unit.
interface muldiv_iter_if #(
    parameter int WIDTH = 32
);
    logic               start_i;
    logic               annul_i;
    logic [1:0]         op_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               busy_o;
    logic               dbz_o;

    modport master (
        output start_i, annul_i, op_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, busy_o, dbz_o
    );

    modport slave (
        input  start_i, annul_i, op_i, opdata1_i, opdata2_i,
        output result_o, ready_o, busy_o, dbz_o
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned multiply and restoring divide, one bit per cycle, {hi,lo} result.
// Operands are reduced to magnitudes at start; sign correction is applied on the final step.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          reset,
    muldiv_iter_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] v);
        return ~v + ONE_2W;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [2*WIDTH-1:0] pend_res_q, pend_res_d;
    logic               pend_dbz_q, pend_dbz_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               dbz_q, dbz_d;

    logic               sign1_s, sign2_s;
    logic [WIDTH-1:0]   mag1_s, mag2_s;
    logic [WIDTH:0]     mul_hi_s, add_s, shifted_s, trial_s, rem_step_s;
    logic [WIDTH-1:0]   quo_step_s;
    logic [2*WIDTH-1:0] final_s;
    logic               ready_s;

    // Start-cycle operand decode: MULT and DIV (op bit 0 clear) are the signed ops
    always_comb begin
        sign1_s = ~bus.op_i[0] & bus.opdata1_i[WIDTH-1];
        sign2_s = ~bus.op_i[0] & bus.opdata2_i[WIDTH-1];
        if (sign1_s) begin
            mag1_s = negate_w(bus.opdata1_i);
        end else begin
            mag1_s = bus.opdata1_i;
        end
        if (sign2_s) begin
            mag2_s = negate_w(bus.opdata2_i);
        end else begin
            mag2_s = bus.opdata2_i;
        end
    end

    // One iteration: shift-add for multiply, restoring subtract for divide
    always_comb begin
        mul_hi_s   = rem_q + {1'b0, opb_q};
        shifted_s  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        trial_s    = shifted_s - {1'b0, opb_q};
        add_s      = rem_q;
        rem_step_s = rem_q;
        quo_step_s = quo_q;
        if (op_q[1]) begin
            if (!trial_s[WIDTH]) begin
                rem_step_s = trial_s;
                quo_step_s = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_step_s = shifted_s;
                quo_step_s = {quo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (quo_q[0]) begin
                add_s = mul_hi_s;
            end else begin
                add_s = rem_q;
            end
            rem_step_s = {1'b0, add_s[WIDTH:1]};
            quo_step_s = {add_s[0], quo_q[WIDTH-1:1]};
        end
    end

    // Sign correction of the last step's {hi,lo}
    always_comb begin
        final_s = {rem_step_s[WIDTH-1:0], quo_step_s};
        if (op_q[1]) begin
            if (neg_q) begin
                final_s[WIDTH-1:0] = negate_w(quo_step_s);
            end else begin
                final_s[WIDTH-1:0] = quo_step_s;
            end
            if (rneg_q) begin
                final_s[2*WIDTH-1:WIDTH] = negate_w(rem_step_s[WIDTH-1:0]);
            end else begin
                final_s[2*WIDTH-1:WIDTH] = rem_step_s[WIDTH-1:0];
            end
        end else begin
            if (neg_q) begin
                final_s = negate_2w({rem_step_s[WIDTH-1:0], quo_step_s});
            end else begin
                final_s = {rem_step_s[WIDTH-1:0], quo_step_s};
            end
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        neg_d      = neg_q;
        rneg_d     = rneg_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        opb_d      = opb_q;
        pend_res_d = pend_res_q;
        pend_dbz_d = pend_dbz_q;
        result_d   = result_q;
        dbz_d      = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i && !bus.annul_i) begin
                    op_d   = bus.op_i;
                    neg_d  = sign1_s ^ sign2_s;
                    rneg_d = sign1_s;
                    rem_d  = {1'b0, ZERO_W};
                    quo_d  = mag1_s;
                    opb_d  = mag2_s;
                    cnt_d  = CNT_ZERO;
                    if (bus.op_i[1] && (bus.opdata2_i == ZERO_W)) begin
                        state_d    = ST_DONE;
                        pend_res_d = {bus.opdata1_i, ONES_W};
                        pend_dbz_d = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (bus.annul_i) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d = rem_step_s;
                    quo_d = quo_step_s;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d    = ST_DONE;
                        pend_res_d = final_s;
                        pend_dbz_d = 1'b0;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                // Commit only if the pulse was not annulled in this cycle
                if (!bus.annul_i) begin
                    result_d = pend_res_q;
                    dbz_d    = pend_dbz_q;
                end else begin
                    result_d = result_q;
                    dbz_d    = dbz_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            op_q       <= 2'b00;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            rem_q      <= {1'b0, ZERO_W};
            quo_q      <= ZERO_W;
            opb_q      <= ZERO_W;
            pend_res_q <= ZERO_2W;
            pend_dbz_q <= 1'b0;
            result_q   <= ZERO_2W;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            neg_q      <= neg_d;
            rneg_q     <= rneg_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            opb_q      <= opb_d;
            pend_res_q <= pend_res_d;
            pend_dbz_q <= pend_dbz_d;
            result_q   <= result_d;
            dbz_q      <= dbz_d;
        end
    end

    // The DONE cycle presents the pending result so an annul there leaves outputs untouched
    assign ready_s      = (state_q == ST_DONE) & ~bus.annul_i;
    assign bus.ready_o  = ready_s;
    assign bus.result_o = ready_s ? pend_res_q : result_q;
    assign bus.dbz_o    = ready_s ? pend_dbz_q : dbz_q;
    assign bus.busy_o   = (state_q != ST_IDLE);
endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter at WIDTH=32 and WIDTH=8.
module tb_muldiv_iter;
    typedef struct packed {
        logic [63:0] res;
        logic        dbz;
    } exp_t;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    exp_t q32[$];
    exp_t q8[$];
    exp_t last32;

    muldiv_iter_if #(.WIDTH(32)) bus32 ();
    muldiv_iter_if #(.WIDTH(8))  bus8 ();

    muldiv_iter #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    muldiv_iter #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference built on native signed/unsigned 64-bit arithmetic
    function automatic exp_t model(input int w, input logic [1:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        logic [63:0] m, m2, ua, ub, res;
        longint      sa, sb;
        exp_t        e;
        m   = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - w);
        m2  = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - 2 * w);
        ua  = {32'd0, a} & m;
        ub  = {32'd0, b} & m;
        sa  = ua[w-1] ? (longint'(ua) - (longint'(1) <<< w)) : longint'(ua);
        sb  = ub[w-1] ? (longint'(ub) - (longint'(1) <<< w)) : longint'(ub);
        e.dbz = 1'b0;
        res = 64'd0;
        case (op)
            OP_MULT:  res = 64'(sa * sb) & m2;
            OP_MULTU: res = (ua * ub) & m2;
            default: begin
                if (ub == 64'd0) begin
                    res   = (ua << w) | m;
                    e.dbz = 1'b1;
                end else if (op == OP_DIV) begin
                    res = ((64'(sa % sb) & m) << w) | (64'(sa / sb) & m);
                end else begin
                    res = (((ua % ub) & m) << w) | ((ua / ub) & m);
                end
            end
        endcase
        e.res = res;
        return e;
    endfunction

    task automatic drive32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [63:0] res, output logic dbz,
                           output logic busy_ok);
        @(negedge clk);
        bus32.op_i      = op;
        bus32.opdata1_i = a;
        bus32.opdata2_i = b;
        bus32.start_i   = 1'b1;
        q32.push_back(model(32, op, a, b));
        @(posedge clk);
        lat = -1; res = 64'd0; dbz = 1'b0; busy_ok = 1'b1;
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus32.start_i   = 1'b0;
                bus32.op_i      = 2'($urandom);
                bus32.opdata1_i = $urandom;
                bus32.opdata2_i = $urandom;
            end
            if (bus32.busy_o !== 1'b1) busy_ok = 1'b0;
            if (bus32.ready_o === 1'b1) begin
                lat = c; res = bus32.result_o; dbz = bus32.dbz_o;
            end
        end
    endtask

    task automatic drive8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output logic [15:0] res, output logic dbz);
        @(negedge clk);
        bus8.op_i      = op;
        bus8.opdata1_i = a;
        bus8.opdata2_i = b;
        bus8.start_i   = 1'b1;
        q8.push_back(model(8, op, {24'd0, a}, {24'd0, b}));
        @(posedge clk);
        lat = -1; res = 16'd0; dbz = 1'b0;
        for (int c = 1; c <= 30 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus8.start_i   = 1'b0;
                bus8.opdata1_i = 8'($urandom);
                bus8.opdata2_i = 8'($urandom);
            end
            if (bus8.ready_o === 1'b1) begin
                lat = c; res = bus8.result_o; dbz = bus8.dbz_o;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus32.result_o !== 64'd0) begin failures++; $display("FAIL reset_result: got %h expected 0", bus32.result_o); end
        checks++; if (bus32.ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", bus32.ready_o); end
        checks++; if (bus32.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus32.busy_o); end
        checks++; if (bus32.dbz_o !== 1'b0) begin failures++; $display("FAIL reset_dbz: got %b expected 0", bus32.dbz_o); end
        checks++; if ({bus8.result_o, bus8.ready_o, bus8.busy_o, bus8.dbz_o} !== 19'd0) begin
            failures++; $display("FAIL reset_w8: got %h expected 0", {bus8.result_o, bus8.ready_o, bus8.busy_o, bus8.dbz_o});
        end
        reset = 1'b1;
    endtask

    task automatic test_multu();
        int lat; logic [63:0] res; logic dbz; logic bok; exp_t e;
        drive32(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, dbz, bok);
        e = q32.pop_front(); last32 = e;
        checks++; if (lat !== 33) begin failures++; $display("FAIL multu_latency: got %0d expected 33", lat); end
        checks++; if (res !== 64'hFFFF_FFFE_0000_0001) begin failures++; $display("FAIL multu_result: got %h expected fffffffe00000001", res); end
        checks++; if (bok !== 1'b1) begin failures++; $display("FAIL multu_busy: got low in cycles 1-33 expected high"); end
        @(negedge clk);
        checks++; if ({bus32.ready_o, bus32.busy_o} !== 2'b00) begin
            failures++; $display("FAIL multu_after: got ready/busy %b expected 00", {bus32.ready_o, bus32.busy_o});
        end
    endtask

    task automatic test_signed();
        int lat; logic [63:0] res; logic dbz; logic bok; exp_t e;
        logic [1:0]  ops [0:6] = '{OP_DIV, OP_MULT, OP_DIV, OP_DIVU, OP_MULT, OP_DIV, OP_MULTU};
        logic [31:0] as  [0:6] = '{32'h8000_0000, 32'h8000_0000, 32'd7, 32'hFFFF_FFFF, 32'd12345, 32'hFFFF_FFF9, 32'h0001_0000};
        logic [31:0] bs  [0:6] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'd7, 32'h0001_0000};
        logic [1:0]  op; logic [31:0] a, b;
        drive32(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat, res, dbz, bok);
        e = q32.pop_front(); last32 = e;
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFF1) begin failures++; $display("FAIL mult_neg3x5: got %h expected fffffffffffffff1", res); end
        drive32(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, res, dbz, bok);
        e = q32.pop_front(); last32 = e;
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL div_neg7by2: got %h expected fffffffffffffffd", res); end
        for (int i = 0; i < 13; i++) begin
            if (i < 7) begin
                op = ops[i]; a = as[i]; b = bs[i];
            end else begin
                op = 2'($urandom); a = $urandom; b = (i == 9) ? 32'd0 : $urandom;
            end
            drive32(op, a, b, lat, res, dbz, bok);
            e = q32.pop_front(); last32 = e;
            checks++; if (res !== e.res) begin failures++; $display("FAIL arith32_result[%0d] op=%b: got %h expected %h", i, op, res, e.res); end
            checks++; if (dbz !== e.dbz) begin failures++; $display("FAIL arith32_dbz[%0d]: got %b expected %b", i, dbz, e.dbz); end
            checks++; if (lat !== (e.dbz ? 1 : 33)) begin failures++; $display("FAIL arith32_latency[%0d]: got %0d expected %0d", i, lat, e.dbz ? 1 : 33); end
        end
    endtask

    task automatic test_dbz();
        int lat; logic [63:0] res; logic dbz; logic bok; exp_t e;
        drive32(OP_DIVU, 32'd100, 32'd0, lat, res, dbz, bok);
        e = q32.pop_front(); last32 = e;
        checks++; if (lat !== 1) begin failures++; $display("FAIL dbz_latency: got %0d expected 1", lat); end
        checks++; if (dbz !== 1'b1) begin failures++; $display("FAIL dbz_flag: got %b expected 1", dbz); end
        checks++; if (res !== 64'h0000_0064_FFFF_FFFF) begin failures++; $display("FAIL dbz_result: got %h expected 00000064ffffffff", res); end
        @(negedge clk);
        checks++; if (bus32.dbz_o !== 1'b1) begin failures++; $display("FAIL dbz_hold: got %b expected 1", bus32.dbz_o); end
        drive32(OP_DIVU, 32'd100, 32'd7, lat, res, dbz, bok);
        e = q32.pop_front(); last32 = e;
        checks++; if (dbz !== 1'b0) begin failures++; $display("FAIL dbz_clear: got %b expected 0", dbz); end
        checks++; if (res !== 64'h0000_0002_0000_000E) begin failures++; $display("FAIL divu_100by7: got %h expected 000000020000000e", res); end
        checks++; if (lat !== 33) begin failures++; $display("FAIL divu_latency: got %0d expected 33", lat); end
    endtask

    task automatic test_annul();
        int lat; logic [63:0] res; logic dbz; logic bok; exp_t e; logic saw_ready;
        @(negedge clk);
        bus32.op_i = OP_DIVU; bus32.opdata1_i = 32'd100; bus32.opdata2_i = 32'd7; bus32.start_i = 1'b1;
        @(posedge clk);
        saw_ready = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 1) bus32.start_i = 1'b0;
            if (c == 10) bus32.annul_i = 1'b1;
            if (c == 11) begin
                bus32.annul_i = 1'b0;
                checks++; if (bus32.busy_o !== 1'b0) begin failures++; $display("FAIL annul_busy: got %b expected 0", bus32.busy_o); end
            end
            if (bus32.ready_o === 1'b1) saw_ready = 1'b1;
        end
        checks++; if (saw_ready !== 1'b0) begin failures++; $display("FAIL annul_ready: got 1 expected 0"); end
        checks++; if (bus32.result_o !== last32.res) begin failures++; $display("FAIL annul_result_hold: got %h expected %h", bus32.result_o, last32.res); end
        drive32(OP_DIVU, 32'd100, 32'd7, lat, res, dbz, bok);
        e = q32.pop_front(); last32 = e;
        checks++; if (res !== e.res || lat !== 33) begin failures++; $display("FAIL annul_restart: got %h lat %0d expected %h lat 33", res, lat, e.res); end
    endtask

    task automatic test_back_to_back();
        int first, second, nready; exp_t e;
        @(negedge clk);
        bus32.op_i = OP_DIVU; bus32.opdata1_i = 32'd1000; bus32.opdata2_i = 32'd9; bus32.start_i = 1'b1;
        q32.push_back(model(32, OP_DIVU, 32'd1000, 32'd9));
        q32.push_back(model(32, OP_DIVU, 32'd1000, 32'd9));
        @(posedge clk);
        first = -1; second = -1; nready = 0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (bus32.ready_o === 1'b1) begin
                nready++;
                if (first < 0) first = c;
                else if (second < 0) begin second = c; bus32.start_i = 1'b0; end
                if (q32.size() > 0) begin
                    e = q32.pop_front(); last32 = e;
                    checks++; if (bus32.result_o !== e.res) begin failures++; $display("FAIL b2b_result: got %h expected %h", bus32.result_o, e.res); end
                end
            end
        end
        bus32.start_i = 1'b0;
        checks++; if (first !== 33 || second !== 67) begin failures++; $display("FAIL b2b_timing: got %0d,%0d expected 33,67", first, second); end
        checks++; if (nready !== 2) begin failures++; $display("FAIL b2b_count: got %0d expected 2", nready); end
        q32.delete();
    endtask

    task automatic test_width8();
        int lat; logic [15:0] res; logic dbz; exp_t e;
        logic [1:0] op; logic [7:0] a, b;
        drive8(OP_DIV, 8'h80, 8'hFF, lat, res, dbz);
        e = q8.pop_front();
        checks++; if (lat !== 9) begin failures++; $display("FAIL w8_div_latency: got %0d expected 9", lat); end
        checks++; if (res !== 16'h0080 || dbz !== 1'b0) begin failures++; $display("FAIL w8_div_overflow: got %h dbz %b expected 0080 dbz 0", res, dbz); end
        drive8(OP_MULT, 8'h80, 8'h80, lat, res, dbz);
        e = q8.pop_front();
        checks++; if (res !== 16'h4000) begin failures++; $display("FAIL w8_mult_minsq: got %h expected 4000", res); end
        for (int i = 0; i < 16; i++) begin
            op = 2'(i);
            a  = 8'($urandom);
            b  = (i == 6 || i == 11) ? 8'd0 : 8'($urandom);
            drive8(op, a, b, lat, res, dbz);
            e = q8.pop_front();
            checks++; if (res !== e.res[15:0] || dbz !== e.dbz) begin
                failures++; $display("FAIL w8_random[%0d] op=%b a=%h b=%h: got %h/%b expected %h/%b", i, op, a, b, res, dbz, e.res[15:0], e.dbz);
            end
            checks++; if (lat !== (e.dbz ? 1 : 9)) begin failures++; $display("FAIL w8_latency[%0d]: got %0d expected %0d", i, lat, e.dbz ? 1 : 9); end
        end
    endtask

    task automatic test_async_reset();
        int lat; exp_t e;
        @(negedge clk);
        bus32.op_i = OP_MULTU; bus32.opdata1_i = 32'h1234_5678; bus32.opdata2_i = 32'h9ABC_DEF0; bus32.start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus32.start_i = 1'b0;
        repeat (8) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if ({bus32.result_o, bus32.ready_o, bus32.busy_o, bus32.dbz_o} !== 67'd0) begin
            failures++; $display("FAIL async_reset_outputs: got %h/%b/%b/%b expected all 0", bus32.result_o, bus32.ready_o, bus32.busy_o, bus32.dbz_o);
        end
        bus32.op_i = OP_MULT; bus32.opdata1_i = 32'hFFFF_FFFD; bus32.opdata2_i = 32'd5; bus32.start_i = 1'b1;
        q32.push_back(model(32, OP_MULT, 32'hFFFF_FFFD, 32'd5));
        #1 reset = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 1) bus32.start_i = 1'b0;
            if (bus32.ready_o === 1'b1) begin
                lat = c;
                e = q32.pop_front(); last32 = e;
                checks++; if (bus32.result_o !== e.res) begin failures++; $display("FAIL async_restart_result: got %h expected %h", bus32.result_o, e.res); end
            end
        end
        checks++; if (lat !== 33) begin failures++; $display("FAIL async_restart_latency: got %0d expected 33", lat); end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0;
        bus32.start_i = 1'b0; bus32.annul_i = 1'b0; bus32.op_i = 2'b00;
        bus32.opdata1_i = 32'd0; bus32.opdata2_i = 32'd0;
        bus8.start_i = 1'b0; bus8.annul_i = 1'b0; bus8.op_i = 2'b00;
        bus8.opdata1_i = 8'd0; bus8.opdata2_i = 8'd0;
        last32 = '{res: 64'd0, dbz: 1'b0};
        test_reset();
        test_multu();
        test_signed();
        test_dbz();
        test_annul();
        test_back_to_back();
        test_width8();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
Parametrised iterative multiply/divide unit for the execute stage. It is the successor to the divide-only unit. It handles signed and unsigned multiply and divide at any operand WIDTH and runs one operation at a time. The execute stage holds its stall request on start_i. The unit returns a {hi,lo} pair formatted for the HI/LO register write, with divide-by-zero reporting and annul support.

Parameters:
WIDTH, 32, operand width in bits; legal values are WIDTH >= 2.
CNT_W, $clog2(WIDTH)+1, width of the iteration counter; derived, must not be overridden.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start_i  in  1  request to start an operation; level-sensitive, sampled only in IDLE.
annul_i  in  1  abort the current operation; has priority over start_i.
op_i  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
opdata1_i  in  WIDTH  multiplicand or dividend.
opdata2_i  in  WIDTH  multiplier or divisor.
result_o  out  2*WIDTH  result as {hi,lo}: the product for multiply, {remainder,quotient} for divide.
ready_o  out  1  one-cycle pulse; result_o is valid in this cycle.
busy_o  out  1  high in CALC and DONE.
dbz_o  out  1  divide-by-zero flag for the last completed operation.

Behaviour:
- Reset is asynchronous, active when reset=0. On reset: state=IDLE; result_o=0, ready_o=0, busy_o=0, dbz_o=0; counter and working registers cleared.
- A reset during CALC or DONE aborts the operation immediately. No ready_o pulse follows.
- State machine: IDLE, CALC, DONE.
- IDLE:
  - If start_i=1 and annul_i=0, latch op_i and both operands.
  - For signed ops, convert the operands to magnitudes and record the result signs: product/quotient sign = sign1 XOR sign2; remainder sign = sign1.
  - If op is DIV/DIVU and opdata2_i=0, go to DONE and set the dbz result. Otherwise clear the counter and go to CALC.
- CALC:
  - Multiply: one shift-add step per cycle.
  - Divide: one restoring-divide step per cycle.
  - Exactly WIDTH cycles; counter runs 0..WIDTH-1. After the last step go to DONE.
- DONE:
  - Apply sign correction (two's-complement negate) and register result_o.
  - ready_o=1 for exactly this cycle. Next state is always IDLE.
- Latency: start accepted on edge 0 gives ready_o high in cycle WIDTH+1. Divide by zero gives ready_o in cycle 1.
- result_o holds its value until the next DONE. It does not change in IDLE or CALC, or on annul.
- dbz_o is updated in DONE and held until the next DONE.
- Divide-by-zero result: quotient = all ones, remainder = dividend as given (unmodified); dbz_o=1.
- Signed overflow case, DIV with most-negative dividend / -1: quotient = most-negative value (wraps), remainder = 0, dbz_o=0.
- Remainder is always |r| < |divisor|.
- Multiply never overflows the 2*WIDTH result; MULT gives the exact two's-complement product.
- annul_i=1 in CALC or DONE: next state IDLE. No ready_o pulse in that or later cycles; result_o and dbz_o unchanged.
- annul_i=1 in IDLE: blocks start that cycle.
- start_i in CALC or DONE is ignored.
- The stage must drop start_i in the ready_o cycle. If start_i is still high in the following IDLE cycle, a new operation starts.
- busy_o = (state != IDLE), taken from registered state.
- Operands may change after the start edge without effect on the running operation.

Test Plan:
- WIDTH=32, MULTU 0xFFFFFFFF x 0xFFFFFFFF -> ready_o pulse in cycle 33 only; result_o = 0xFFFFFFFE_00000001; busy_o high cycles 1-33.
- MULT -3 x 5 -> result_o = 0xFFFFFFFF_FFFFFFF1. DIV -7 / 2 -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}, i.e. r=-1, q=-3.
- DIVU 100 / 0 -> ready_o in cycle 1, dbz_o=1, result_o = {0x00000064, 0xFFFFFFFF}. A subsequent DIVU 100 / 7 -> dbz_o=0, result_o = {2, 14}.
- DIVU 100 / 7 with annul_i pulsed in cycle 10 -> no ready_o; busy_o=0 from cycle 11; result_o keeps its prior value. Then start again -> correct result 33 cycles later.
- Instance with WIDTH=8: DIV 0x80 / 0xFF -> ready_o in cycle 9, result_o = 0x0080, dbz_o=0. MULT 0x80 x 0x80 -> 0x4000.
- reset driven low asynchronously mid-CALC (between edges) -> all outputs 0 immediately. After release: no ready_o; start_i held high in IDLE starts a new operation.
